// File: rtl/p2s_lanes.sv
// Parallel-to-serial converter: accepts N-bit words and emits them as BEATS
// W-bit beats, with a one-word holding register so words stream without bubbles.
module p2s_lanes #(
  parameter int N         = 8,
  parameter int W         = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] par_data,
  input  logic         par_valid,
  output logic         par_ready,
  output logic [W-1:0] ser_data,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         ser_last
);

  localparam int BEATS = N / W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  if (N % W != 0) begin : g_bad_width
    $error("p2s_lanes: N must be a multiple of W");
  end

  logic [N-1:0]  shift_q, shift_d;
  logic [N-1:0]  shifted;
  logic [N-1:0]  hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          hold_full_q, hold_full_d;
  logic          beat_xfer;
  logic          last_beat;
  logic          word_xfer;

  // The outgoing slice always sits at a fixed end of the shift register, so the
  // output needs no cnt-indexed multiplexer.
  if (BEATS > 1) begin : g_shift
    if (MSB_FIRST) begin : g_msb
      assign shifted  = {shift_q[N-W-1:0], {W{1'b0}}};
      assign ser_data = shift_q[N-1 -: W];
    end else begin : g_lsb
      assign shifted  = {{W{1'b0}}, shift_q[N-1:W]};
      assign ser_data = shift_q[W-1:0];
    end
  end else begin : g_single
    assign shifted  = shift_q;
    assign ser_data = shift_q;
  end

  assign ser_valid = busy_q;
  assign ser_last  = busy_q && (cnt_q == LAST_CNT);
  assign par_ready = rstn && !hold_full_q;

  assign beat_xfer = busy_q && ser_ready;
  assign last_beat = beat_xfer && (cnt_q == LAST_CNT);
  assign word_xfer = par_valid && par_ready;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    shift_d     = shift_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    hold_full_d = hold_full_q;

    if (beat_xfer) begin
      shift_d = shifted;
      cnt_d   = cnt_q + CW'(1);
      if (last_beat) begin
        cnt_d = '0;
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
        end else begin
          busy_d = 1'b0;
        end
      end
    end

    // par_ready is low whenever hold is full, so a word never collides with the
    // hold-to-shift move above.
    if (word_xfer) begin
      if (!busy_q || last_beat) begin
        shift_d = par_data;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end else begin
        hold_d      = par_data;
        hold_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: data registers are cleared too, so ser_data reads 0 out of reset
      // and no stale word can ever resurface.
      shift_q     <= '0;
      hold_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      hold_full_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep all registers sampling the same edge.
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      hold_full_q <= hold_full_d;
    end
  end

endmodule

// File: doc/p2s_lanes.md
P2S_LANES -- requirements
Module: p2s_lanes

Interface
REQ-001 The block SHALL have parameter N, default 8: parallel word width in bits.
REQ-002 The block SHALL have parameter W, default 1: serial lane width in bits per beat; N mod W SHALL be 0, else elaboration error.
REQ-003 The block SHALL have parameter MSB_FIRST, default 0: 1 = most-significant W-bit slice sent first, 0 = least-significant slice first.
REQ-004 The block SHALL define derived constant BEATS = N/W, the serial beats per word.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rstn, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port par_data, input, N bits: parallel word.
REQ-008 The block SHALL have port par_valid, input, 1 bit: par_data valid.
REQ-009 The block SHALL have port par_ready, output, 1 bit: block can accept a word.
REQ-010 The block SHALL have port ser_data, output, W bits: current serial beat.
REQ-011 The block SHALL have port ser_valid, output, 1 bit: ser_data valid.
REQ-012 The block SHALL have port ser_ready, input, 1 bit: downstream accepts a beat.
REQ-013 The block SHALL have port ser_last, output, 1 bit: current beat is the final beat of its word.

Function
REQ-014 A word SHALL transfer on any rising edge where par_valid and par_ready are both 1, and a beat SHALL transfer on any rising edge where ser_valid and ser_ready are both 1.
REQ-015 Storage SHALL be two entries: a shift register holding the word in flight plus beat counter cnt (0..BEATS-1), and one holding register with flag hold_full.
REQ-016 par_ready SHALL be !hold_full, driven combinationally, and forced to 0 while rstn = 0.
REQ-017 An accepted word SHALL load the shift register (cnt = 0) when the shift register is empty, or is emptying on the same edge because its last beat transfers; otherwise it SHALL load the holding register.
REQ-018 When the last beat transfers and hold_full = 1, the holding register SHALL move into the shift register (cnt = 0) and hold_full SHALL clear on the same edge; that same edge SHALL NOT accept a new word, because par_ready = 0.
REQ-019 ser_valid SHALL equal 1 exactly when the shift register holds a word.
REQ-020 ser_last SHALL be ser_valid AND (cnt = BEATS-1).
REQ-021 For MSB_FIRST = 1, ser_data SHALL be slice [N-1-cnt*W -: W] of the word; for MSB_FIRST = 0 it SHALL be slice [cnt*W +: W].
REQ-022 cnt SHALL increment on each beat transfer and return to 0 after BEATS-1; cnt SHALL be held when no beat transfers.
REQ-023 ser_data, ser_last and cnt SHALL stay stable while ser_valid = 1 and ser_ready = 0.
REQ-024 Latency SHALL be one edge: a word accepted into an empty block shows ser_valid = 1 with its first beat in the following cycle.
REQ-025 With par_valid and ser_ready held at 1, ser_valid SHALL stay 1 with no bubble between words, giving one word per BEATS cycles.
REQ-026 BEATS = 1 SHALL be supported: each beat has ser_last = 1, and the block SHALL act as a 2-deep pipeline buffer.
REQ-027 par_data SHALL be sampled only on the accept edge; later changes to par_data SHALL have no effect on the stored word.

Reset
REQ-028 While rstn = 0 at a rising edge, the block SHALL apply: ser_valid = 0, ser_last = 0, ser_data = 0, cnt = 0, hold_full = 0, shift register and holding register = 0.
REQ-029 A reset asserted mid-word SHALL discard all in-flight and held words with no partial completion, and SHALL give par_ready = 1 on the first cycle after rstn returns to 1.

Verification
REQ-030 Bench SHALL cover, with N=8, W=2, MSB_FIRST=1: par_data = 8'hB4, one accept, ser_ready=1 -> ser_data 2'b10, 2'b11, 2'b01, 2'b00 on consecutive cycles, with ser_last only on the 4th beat.
REQ-031 Bench SHALL cover the same stimulus with MSB_FIRST=0 -> beats 2'b00, 2'b01, 2'b11, 2'b10.
REQ-032 Bench SHALL cover back-to-back 8'hB4 then 8'h5A, par_valid and ser_ready held at 1 -> 8 consecutive valid beats with no gap, ser_last on beats 4 and 8, and par_ready low from the edge 8'h5A enters the holding register until the 4th beat of 8'hB4.
REQ-033 Bench SHALL cover ser_ready=0 for 3 cycles after beat 2 of 8'hB4 -> ser_data stays 2'b11 with ser_valid=1, then resumes at 2'b01 with no beat lost or duplicated.
REQ-034 Bench SHALL cover rstn=0 for one edge during beat 2 with a second word held -> next cycle ser_valid=0, ser_data=0, par_ready=1 after release, and neither word re-emerges.
REQ-035 Bench SHALL cover N=8, W=8 with 3 words streamed -> every beat has ser_last=1 and each word appears whole on ser_data one cycle after its accept edge.
